// File: rtl/ir_hdng_fuse_pkg.sv
// Shared types and defaults for the IR heading fusion stage.
package ir_pkg;

  // Encoding is {lft_opn, rght_opn}; BOTH means both walls are present.
  typedef enum logic [1:0] {
    BOTH  = 2'b00,
    R_OPN = 2'b01,
    L_OPN = 2'b10,
    NONE  = 2'b11
  } wall_mode_t;

  localparam logic [11:0] NOM_IR_DFLT = 12'h970;

endpackage

// File: rtl/ir_hdng_fuse_mov_avg.sv
// Moving-average window with a running sum. A flush pre-loads every slot with
// the incoming value. avg reflects the post-update sum in the same cycle.
module ir_mov_avg #(
  parameter int W        = 13,
  parameter int AVG_LOG2 = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push,
  input  logic                flush,
  input  logic signed [W-1:0] din,
  output logic signed [W-1:0] avg
);

  localparam int D  = 1 << AVG_LOG2;
  localparam int WS = W + AVG_LOG2;

  logic signed [W-1:0]  win_q [D];
  logic signed [W-1:0]  win_d [D];
  logic signed [WS-1:0] sum_q, sum_d;
  logic signed [WS-1:0] din_x, old_x, sum_shr;

  assign din_x   = {{AVG_LOG2{din[W-1]}}, din};
  assign old_x   = {{AVG_LOG2{win_q[D-1][W-1]}}, win_q[D-1]};
  assign sum_shr = sum_d >>> AVG_LOG2;
  assign avg     = sum_shr[W-1:0];

  always_comb begin
    sum_d = sum_q;
    for (int i = 0; i < D; i++) win_d[i] = win_q[i];
    if (push) begin
      if (flush) begin
        for (int i = 0; i < D; i++) win_d[i] = din;
        sum_d = din_x <<< AVG_LOG2;
      end else begin
        win_d[0] = din;
        for (int i = 1; i < D; i++) win_d[i] = win_q[i-1];
        sum_d = sum_q + din_x - old_x;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
      for (int i = 0; i < D; i++) win_q[i] <= '0;
    end else begin
      sum_q <= sum_d;
      for (int i = 0; i < D; i++) win_q[i] <= win_d[i];
    end
  end

endmodule

// File: rtl/ir_hdng_fuse.sv
// IR wall-sensor fusion: debounced wall mode, wall-following error, moving
// average, derivative term and saturated heading adjust. Two-stage pipeline.
module ir_hdng_fuse
  import ir_pkg::*;
#(
  parameter int              W_IR      = 12,
  parameter int              W_HDNG    = 12,
  parameter int              W_DTRM    = 9,
  parameter logic [W_IR-1:0] NOM_IR    = NOM_IR_DFLT,
  parameter int              AVG_LOG2  = 2,
  parameter int              ERR_SHIFT = 5,
  parameter int              OPN_DB    = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     smpl_vld,
  input  logic                     lft_opn,
  input  logic                     rght_opn,
  input  logic        [W_IR-1:0]   lft_IR,
  input  logic        [W_IR-1:0]   rght_IR,
  input  logic signed [W_DTRM-1:0] IR_Dtrm,
  input  logic                     en_fusion,
  input  logic signed [W_HDNG-1:0] dsrd_hdng,
  output logic signed [W_HDNG-1:0] dsrd_hdng_adj,
  output logic                     adj_vld,
  output logic        [1:0]        wall_mode,
  output logic                     sat
);

  localparam int W_ERR = W_IR + 1;
  localparam int W_F   = W_IR + 3;
  localparam int W_ADJ = W_HDNG + 2;
  localparam int CW    = (OPN_DB > 1) ? $clog2(OPN_DB) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(OPN_DB - 1);
  localparam logic signed [W_ADJ-1:0] HMAX = {3'b000, {(W_HDNG-1){1'b1}}};
  localparam logic signed [W_ADJ-1:0] HMIN = {3'b111, {(W_HDNG-1){1'b0}}};

  // Stage 1 state
  wall_mode_t               mode_q, mode_d, raw;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     s1_vld_q, s1_vld_d;
  logic                     flush_q, flush_d;
  logic                     en_q, en_d;
  logic signed [W_ERR-1:0]  err_q, err_d;
  logic signed [W_HDNG-1:0] dsrd_q, dsrd_d;
  logic signed [W_DTRM-1:0] dtrm_q, dtrm_d;

  // Stage 2 state
  logic signed [W_HDNG-1:0] adj_q, adj_d;
  logic                     adj_vld_q, adj_vld_d;
  logic                     sat_q, sat_d;

  logic signed [W_ERR-1:0]  lft_x, rght_x, nom_x, diff_lr;
  logic signed [W_ERR-1:0]  avg;
  logic signed [W_F-1:0]    avg_x, dtrm_x, f_val;
  logic signed [W_ADJ-1:0]  hdng_x, f_adj, adj_full;

  assign lft_x   = $signed({1'b0, lft_IR});
  assign rght_x  = $signed({1'b0, rght_IR});
  assign nom_x   = $signed({1'b0, NOM_IR});
  assign diff_lr = lft_x - rght_x;

  always_comb begin
    raw      = wall_mode_t'({lft_opn, rght_opn});
    mode_d   = mode_q;
    cnt_d    = cnt_q;
    flush_d  = flush_q;
    err_d    = err_q;
    dsrd_d   = dsrd_q;
    dtrm_d   = dtrm_q;
    en_d     = en_q;
    s1_vld_d = smpl_vld;
    if (smpl_vld) begin
      flush_d = 1'b0;
      if (raw == mode_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
        mode_d  = raw;
        cnt_d   = '0;
        flush_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      // The sample is interpreted with the mode it may have just switched to.
      case (mode_d)
        BOTH:    err_d = diff_lr >>> 1;
        R_OPN:   err_d = lft_x - nom_x;
        L_OPN:   err_d = nom_x - rght_x;
        default: err_d = '0;
      endcase
      dsrd_d = dsrd_hdng;
      dtrm_d = IR_Dtrm;
      en_d   = en_fusion;
    end
  end

  ir_mov_avg #(
    .W        (W_ERR),
    .AVG_LOG2 (AVG_LOG2)
  ) u_mov_avg (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (s1_vld_q),
    .flush (flush_q),
    .din   (err_q),
    .avg   (avg)
  );

  assign avg_x    = {{(W_F-W_ERR){avg[W_ERR-1]}}, avg};
  assign dtrm_x   = {{(W_F-W_DTRM){dtrm_q[W_DTRM-1]}}, dtrm_q} <<< 2;
  assign f_val    = ((avg_x >>> ERR_SHIFT) + dtrm_x) >>> 1;
  assign f_adj    = W_ADJ'(f_val);
  assign hdng_x   = {{2{dsrd_q[W_HDNG-1]}}, dsrd_q};
  assign adj_full = hdng_x + f_adj;

  always_comb begin
    adj_d     = adj_q;
    sat_d     = sat_q;
    adj_vld_d = s1_vld_q;
    if (s1_vld_q) begin
      if (!en_q) begin
        adj_d = dsrd_q;
        sat_d = 1'b0;
      end else if (adj_full > HMAX) begin
        adj_d = HMAX[W_HDNG-1:0];
        sat_d = 1'b1;
      end else if (adj_full < HMIN) begin
        adj_d = HMIN[W_HDNG-1:0];
        sat_d = 1'b1;
      end else begin
        adj_d = adj_full[W_HDNG-1:0];
        sat_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= BOTH;
      cnt_q     <= '0;
      s1_vld_q  <= 1'b0;
      flush_q   <= 1'b0;
      en_q      <= 1'b0;
      err_q     <= '0;
      dsrd_q    <= '0;
      dtrm_q    <= '0;
      adj_q     <= '0;
      adj_vld_q <= 1'b0;
      sat_q     <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      cnt_q     <= cnt_d;
      s1_vld_q  <= s1_vld_d;
      flush_q   <= flush_d;
      en_q      <= en_d;
      err_q     <= err_d;
      dsrd_q    <= dsrd_d;
      dtrm_q    <= dtrm_d;
      adj_q     <= adj_d;
      adj_vld_q <= adj_vld_d;
      sat_q     <= sat_d;
    end
  end

  assign dsrd_hdng_adj = adj_q;
  assign adj_vld       = adj_vld_q;
  assign wall_mode     = mode_q;
  assign sat           = sat_q;

endmodule

// File: tb/tb_ir_hdng_fuse.sv
// Directed plus random bench for ir_hdng_fuse against an arithmetic reference
// model; a second instance built with OPN_DB=1 checks immediate mode switching.
module tb_ir_hdng_fuse;

  localparam int NOM = 'h970;
  localparam int DB  = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        smpl_vld, lft_opn, rght_opn, en_fusion;
  logic [11:0] lft_IR, rght_IR, dsrd_hdng;
  logic [8:0]  IR_Dtrm;
  logic [11:0] dsrd_hdng_adj, adj1;
  logic        adj_vld, sat, vld1, sat1;
  logic [1:0]  wall_mode, mode1;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int   m_mode, m_cnt, m_mode1;
  int   win[$];
  logic [11:0] exp_adj[$];
  bit   exp_sat[$];
  bit   pend, cap;

  ir_hdng_fuse dut (
    .clk(clk), .rst_n(rst_n), .smpl_vld(smpl_vld), .lft_opn(lft_opn), .rght_opn(rght_opn),
    .lft_IR(lft_IR), .rght_IR(rght_IR), .IR_Dtrm(IR_Dtrm), .en_fusion(en_fusion),
    .dsrd_hdng(dsrd_hdng), .dsrd_hdng_adj(dsrd_hdng_adj), .adj_vld(adj_vld),
    .wall_mode(wall_mode), .sat(sat)
  );

  ir_hdng_fuse #(.OPN_DB(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .smpl_vld(smpl_vld), .lft_opn(lft_opn), .rght_opn(rght_opn),
    .lft_IR(lft_IR), .rght_IR(rght_IR), .IR_Dtrm(IR_Dtrm), .en_fusion(en_fusion),
    .dsrd_hdng(dsrd_hdng), .dsrd_hdng_adj(adj1), .adj_vld(vld1),
    .wall_mode(mode1), .sat(sat1)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_cnt = 0; m_mode1 = 0;
    win.delete();
    repeat (4) win.push_back(0);
    exp_adj.delete();
    exp_sat.delete();
    pend = 0; cap = 0;
  endtask

  // Applies the behavioural rules to the inputs currently being driven.
  task automatic model_sample();
    int raw, err, sum, avg, f, adj, d, h;
    bit fl, s;
    raw = {lft_opn, rght_opn};
    fl = 0;
    if (raw == m_mode) m_cnt = 0;
    else if (m_cnt == DB - 1) begin m_mode = raw; m_cnt = 0; fl = 1; end
    else m_cnt++;
    m_mode1 = raw;
    case (m_mode)
      0: err = (int'(lft_IR) - int'(rght_IR)) >>> 1;
      1: err = int'(lft_IR) - NOM;
      2: err = NOM - int'(rght_IR);
      default: err = 0;
    endcase
    if (fl) begin
      win.delete();
      repeat (4) win.push_back(err);
    end else begin
      win.push_front(err);
      void'(win.pop_back());
    end
    sum = 0;
    foreach (win[i]) sum += win[i];
    avg = sum >>> 2;
    d = $signed(IR_Dtrm);
    h = $signed(dsrd_hdng);
    f = ((avg >>> 5) + d * 4) >>> 1;
    adj = h + f;
    s = 0;
    if (adj > 2047) begin adj = 2047; s = 1; end
    if (adj < -2048) begin adj = -2048; s = 1; end
    if (!en_fusion) begin adj = h; s = 0; end
    exp_adj.push_back(12'(adj));
    exp_sat.push_back(s);
  endtask

  // One clock; checks outputs just after the edge.
  task automatic cyc();
    bit exp_v;
    @(posedge clk);
    #1;
    exp_v = pend;
    pend  = cap;
    cap   = 0;
    smpl_vld = 1'b0;
    chk("adj_vld", adj_vld, exp_v);
    if (exp_v) begin
      if (exp_adj.size() == 0) begin
        chk("exp_queue_underflow", 1, 0);
      end else begin
        chk("adj", dsrd_hdng_adj, exp_adj.pop_front());
        chk("sat", sat, exp_sat.pop_front());
      end
    end
    chk("wall_mode", wall_mode, m_mode);
    chk("wall_mode_db1", mode1, m_mode1);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic sample(input bit lo, input bit ro, input logic [11:0] l, input logic [11:0] r,
                        input logic [8:0] d, input logic [11:0] h, input bit en);
    lft_opn = lo; rght_opn = ro; lft_IR = l; rght_IR = r;
    IR_Dtrm = d; dsrd_hdng = h; en_fusion = en;
    smpl_vld = 1'b1;
    model_sample();
    cap = 1;
    cyc();
  endtask

  initial begin
    bit lo, ro;
    rst_n = 1'b0; smpl_vld = 1'b0; lft_opn = 1'b0; rght_opn = 1'b0;
    lft_IR = '0; rght_IR = '0; IR_Dtrm = '0; dsrd_hdng = '0; en_fusion = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_adj", dsrd_hdng_adj, 0);
    chk("rst_vld", adj_vld, 0);
    chk("rst_mode", wall_mode, 0);
    chk("rst_sat", sat, 0);
    rst_n = 1'b1;

    // Both walls present, steady error of 0x200
    for (int i = 0; i < 4; i++) sample(0, 0, 12'hB70, 12'h770, 9'h000, 12'h100, 1);
    idle(2);
    chk("both_adj4", dsrd_hdng_adj, 12'h108);

    // Right wall opens: debounce then flush
    for (int i = 0; i < 4; i++) begin
      sample(0, 1, 12'hA70, 12'h770, 9'h000, 12'h100, 1);
      chk("db_mode", wall_mode, (i < 3) ? 0 : 1);
    end
    idle(2);
    chk("flush_adj", dsrd_hdng_adj, 12'h104);

    // Saturation both directions with zero error
    for (int i = 0; i < 4; i++) sample(0, 1, 12'h970, 12'h770, 9'h0FF, 12'h7F0, 1);
    idle(2);
    chk("sat_hi_adj", dsrd_hdng_adj, 12'h7FF);
    chk("sat_hi", sat, 1);
    sample(0, 1, 12'h970, 12'h770, 9'h100, 12'h810, 1);
    idle(2);
    chk("sat_lo_adj", dsrd_hdng_adj, 12'h800);
    chk("sat_lo", sat, 1);

    // Fusion disabled, back-to-back pass-through
    sample(0, 1, 12'hA70, 12'h770, 9'h0FF, 12'h010, 0);
    sample(0, 1, 12'hA70, 12'h770, 9'h0FF, 12'h020, 0);
    chk("pass1_adj", dsrd_hdng_adj, 12'h010);
    chk("pass1_sat", sat, 0);
    idle(1);
    chk("pass2_adj", dsrd_hdng_adj, 12'h020);

    // Both walls open
    sample(1, 1, 12'h123, 12'h456, 9'h000, 12'h155, 1);
    chk("db1_switch", mode1, 3);
    chk("db4_hold", wall_mode, 1);
    for (int i = 0; i < 3; i++) sample(1, 1, 12'h123, 12'h456, 9'h000, 12'h155, 1);
    idle(2);
    chk("none_mode", wall_mode, 3);
    chk("none_adj", dsrd_hdng_adj, 12'h155);
    chk("none_sat", sat, 0);

    // Reset with samples in flight
    lft_opn = 1'b0; rght_opn = 1'b0; lft_IR = 12'hB70; rght_IR = 12'h770;
    IR_Dtrm = 9'h010; dsrd_hdng = 12'h300; en_fusion = 1'b1; smpl_vld = 1'b1;
    @(posedge clk);
    #1;
    dsrd_hdng = 12'h301;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_adj", dsrd_hdng_adj, 0);
    chk("mid_rst_vld", adj_vld, 0);
    chk("mid_rst_mode", wall_mode, 0);
    chk("mid_rst_sat", sat, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    smpl_vld = 1'b0;
    idle(3);
    chk("post_rst_adj", dsrd_hdng_adj, 0);

    // Random traffic with occasional wall changes
    lo = 0; ro = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        lo = 1'($urandom_range(0, 1));
        ro = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 3) != 0)
        sample(lo, ro, 12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)),
               9'($urandom_range(0, 511)), 12'($urandom_range(0, 4095)),
               ($urandom_range(0, 4) != 0));
      else
        idle(1);
    end
    idle(3);
    chk("queue_drained", exp_adj.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
